// File: rtl/anabellek_hakemi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : anabellek_paket (package)
// Purpose  : Shared FSM state encoding, master identifiers and default address
//            width for the L1B/L1V to iomem arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package anabellek_paket;

  // Default word-address width (byte address bits [18:2])
  localparam int ADR_W = 17;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    BOSTA      = 2'd0,
    L1B_HIZMET = 2'd1,
    L1V_HIZMET = 2'd2,
    CEVAP      = 2'd3
  } durum_t;

  // Master identifiers
  typedef enum logic {
    L1B = 1'b0,
    L1V = 1'b1
  } usta_t;

endpackage
`default_nettype wire

// File: rtl/anabellek_hakemi.sv
`default_nettype none
// ============================================================================
// Module   : anabellek_hakemi
// Purpose  : Two-master (instruction cache L1B, data cache L1V), one-slave
//            (iomem) arbiter. One outstanding transaction at a time,
//            round-robin on contention, registered memory-side outputs.
// Options  : ANABELLEK_ZAMAN_ASIMI_EN enables the memory timeout counter and
//            the sticky hata_o flag; without it hata_o is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module anabellek_hakemi #(
  parameter int ADR_W       = anabellek_paket::ADR_W,
  parameter int ZAMAN_ASIMI = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  // Instruction cache (read-only master)
  input  logic [ADR_W-1:0] l1b_adr_i,
  input  logic             l1b_valid_i,
  output logic [31:0]      l1b_rdata_o,
  output logic             l1b_ready_o,
  // Data cache
  input  logic [ADR_W-1:0] l1v_adr_i,
  input  logic             l1v_valid_i,
  input  logic [31:0]      l1v_wdata_i,
  input  logic [3:0]       l1v_wstrb_i,
  output logic [31:0]      l1v_rdata_o,
  output logic             l1v_ready_o,
  // Memory controller port
  output logic [ADR_W-1:0] iomem_adr_o,
  output logic             iomem_valid_o,
  output logic [31:0]      iomem_wdata_o,
  output logic [3:0]       iomem_wstrb_o,
  input  logic [31:0]      iomem_rdata_i,
  input  logic             iomem_ready_i,
  // Sticky timeout flag
  output logic             hata_o
);

  import anabellek_paket::*;

  durum_t      r_durum;
  usta_t       r_son;         // master served most recently
  usta_t       w_secilen;     // master granted if a request is sampled now
  usta_t       w_sahip;       // owner of the transaction in flight
  logic        w_istek;
  logic        w_zaman_doldu; // timeout reached this HIZMET cycle
  logic        w_bitir;       // transaction ends this cycle
  logic [31:0] w_cevap_veri;  // data returned to the owner

  assign w_istek = l1b_valid_i | l1v_valid_i;

  // Round-robin choice: on a tie the master not served last wins
  always_comb begin
    w_secilen = L1B;
    if (l1b_valid_i && l1v_valid_i) begin
      w_secilen = (r_son == L1V) ? L1B : L1V;
    end else if (l1v_valid_i) begin
      w_secilen = L1V;
    end
  end

  // Owner is implied by which service state is active
  always_comb begin
    w_sahip = (r_durum == L1V_HIZMET) ? L1V : L1B;
  end

`ifdef ANABELLEK_ZAMAN_ASIMI_EN
  // At least 8 bits, wider if the timeout limit needs it
  localparam int SAYAC_W = ($clog2(ZAMAN_ASIMI + 1) > 8) ? $clog2(ZAMAN_ASIMI + 1) : 8;

  logic [SAYAC_W-1:0] r_sayac;

  // Counter reads k-1 during the k-th service cycle, so the limit hits on cycle ZAMAN_ASIMI
  assign w_zaman_doldu = (r_durum == L1B_HIZMET || r_durum == L1V_HIZMET) &&
                         (r_sayac == SAYAC_W'(ZAMAN_ASIMI - 1));

  // Service-cycle counter: cleared while idle/at grant, counts each service cycle
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_sayac <= '0;
    end else if (r_durum == L1B_HIZMET || r_durum == L1V_HIZMET) begin
      r_sayac <= r_sayac + SAYAC_W'(1);
    end else begin
      r_sayac <= '0;
    end
  end

  // Sticky error flag, set when a transaction is abandoned for lack of iomem_ready_i
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hata_o <= 1'b0;
    end else if (w_zaman_doldu && !iomem_ready_i) begin
      hata_o <= 1'b1;
    end
  end
`else
  logic w_unused_zaman;

  assign w_zaman_doldu  = 1'b0;
  assign hata_o         = 1'b0;
  assign w_unused_zaman = ^ZAMAN_ASIMI;
`endif

  // A real memory answer wins over a coincident timeout; a timeout returns zero data
  assign w_bitir      = iomem_ready_i | w_zaman_doldu;
  assign w_cevap_veri = iomem_ready_i ? iomem_rdata_i : 32'h0000_0000;

  // Arbitration FSM with registered memory-side and completion outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_durum       <= BOSTA;
      r_son         <= L1V;
      iomem_adr_o   <= '0;
      iomem_valid_o <= 1'b0;
      iomem_wdata_o <= '0;
      iomem_wstrb_o <= '0;
      l1b_rdata_o   <= '0;
      l1b_ready_o   <= 1'b0;
      l1v_rdata_o   <= '0;
      l1v_ready_o   <= 1'b0;
    end else begin
      // Completion strobes are single-cycle pulses
      l1b_ready_o <= 1'b0;
      l1v_ready_o <= 1'b0;
      case (r_durum)
        BOSTA: begin
          if (w_istek) begin
            iomem_valid_o <= 1'b1;
            if (w_secilen == L1V) begin
              iomem_adr_o   <= l1v_adr_i;
              iomem_wdata_o <= l1v_wdata_i;
              iomem_wstrb_o <= l1v_wstrb_i;
              r_durum       <= L1V_HIZMET;
            end else begin
              iomem_adr_o   <= l1b_adr_i;
              iomem_wdata_o <= '0;
              iomem_wstrb_o <= '0;
              r_durum       <= L1B_HIZMET;
            end
          end
        end
        L1B_HIZMET, L1V_HIZMET: begin
          // Requester inputs are ignored here; iomem_* simply hold
          if (w_bitir) begin
            iomem_valid_o <= 1'b0;
            r_son         <= w_sahip;
            r_durum       <= CEVAP;
            if (w_sahip == L1V) begin
              l1v_rdata_o <= w_cevap_veri;
              l1v_ready_o <= 1'b1;
            end else begin
              l1b_rdata_o <= w_cevap_veri;
              l1b_ready_o <= 1'b1;
            end
          end
        end
        CEVAP: begin
          // Skip sampling for one cycle so the owner's stale valid is not re-granted
          r_durum <= BOSTA;
        end
        default: begin
          r_durum <= BOSTA;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_anabellek_hakemi.sv
`default_nettype none
// ============================================================================
// Module   : tb_anabellek_hakemi
// Purpose  : Self-checking bench for anabellek_hakemi: vector table, random
//            transactions against a round-robin reference model, and
//            hand-written multi-cycle corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_anabellek_hakemi;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [16:0] l1b_adr_i;
  logic        l1b_valid_i;
  logic [31:0] l1b_rdata_o;
  logic        l1b_ready_o;
  logic [16:0] l1v_adr_i;
  logic        l1v_valid_i;
  logic [31:0] l1v_wdata_i;
  logic [3:0]  l1v_wstrb_i;
  logic [31:0] l1v_rdata_o;
  logic        l1v_ready_o;
  logic [16:0] iomem_adr_o;
  logic        iomem_valid_o;
  logic [31:0] iomem_wdata_o;
  logic [3:0]  iomem_wstrb_o;
  logic [31:0] iomem_rdata_i;
  logic        iomem_ready_i;
  logic        hata_o;

  always #5 clk_i = ~clk_i;

  anabellek_hakemi #(
    .ADR_W       (17),
    .ZAMAN_ASIMI (8)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .l1b_adr_i     (l1b_adr_i),
    .l1b_valid_i   (l1b_valid_i),
    .l1b_rdata_o   (l1b_rdata_o),
    .l1b_ready_o   (l1b_ready_o),
    .l1v_adr_i     (l1v_adr_i),
    .l1v_valid_i   (l1v_valid_i),
    .l1v_wdata_i   (l1v_wdata_i),
    .l1v_wstrb_i   (l1v_wstrb_i),
    .l1v_rdata_o   (l1v_rdata_o),
    .l1v_ready_o   (l1v_ready_o),
    .iomem_adr_o   (iomem_adr_o),
    .iomem_valid_o (iomem_valid_o),
    .iomem_wdata_o (iomem_wdata_o),
    .iomem_wstrb_o (iomem_wstrb_o),
    .iomem_rdata_i (iomem_rdata_i),
    .iomem_ready_i (iomem_ready_i),
    .hata_o        (hata_o)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: who was served last (0=l1b, 1=l1v) and last data each master got
  int          m_son;
  logic [31:0] last_rd [2];

  typedef struct {
    bit          bv;
    bit          vv;
    logic [16:0] ab;
    logic [16:0] av;
    logic [31:0] wd;
    logic [3:0]  ws;
    int          wt;
    logic [31:0] rd;
    int          own;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset;
    rst_ni        = 1'b0;
    l1b_valid_i   = 1'b0;
    l1v_valid_i   = 1'b0;
    l1b_adr_i     = '0;
    l1v_adr_i     = '0;
    l1v_wdata_i   = '0;
    l1v_wstrb_i   = '0;
    iomem_ready_i = 1'b0;
    iomem_rdata_i = '0;
    tick;
    tick;
    chk("rst_valid", iomem_valid_o, 0);
    chk("rst_adr", iomem_adr_o, 0);
    chk("rst_wdata", iomem_wdata_o, 0);
    chk("rst_wstrb", iomem_wstrb_o, 0);
    chk("rst_ready", {l1b_ready_o, l1v_ready_o}, 0);
    chk("rst_rdata_b", l1b_rdata_o, 0);
    chk("rst_rdata_v", l1v_rdata_o, 0);
    chk("rst_hata", hata_o, 0);
    rst_ni     = 1'b1;
    m_son      = 1;
    last_rd[0] = '0;
    last_rd[1] = '0;
  endtask

  // Called one cycle after the grant edge: check the registered request
  task automatic check_grant(input int own, input logic [16:0] adr,
                             input logic [31:0] wd, input logic [3:0] ws);
    chk("grant_valid", iomem_valid_o, 1);
    chk("grant_adr", iomem_adr_o, adr);
    chk("grant_wdata", iomem_wdata_o, (own == 1) ? wd : 32'h0);
    chk("grant_wstrb", iomem_wstrb_o, (own == 1) ? ws : 4'h0);
  endtask

  // Called inside a service cycle: memory answers, then check CEVAP and return to BOSTA
  task automatic complete(input int own, input logic [31:0] rd, input bit drop_b, input bit drop_v);
    iomem_ready_i = 1'b1;
    iomem_rdata_i = rd;
    tick;
    iomem_ready_i = 1'b0;
    iomem_rdata_i = $urandom;
    if (drop_b) l1b_valid_i = 1'b0;
    if (drop_v) l1v_valid_i = 1'b0;
    chk("owner_ready", (own == 1) ? l1v_ready_o : l1b_ready_o, 1);
    chk("other_ready", (own == 1) ? l1b_ready_o : l1v_ready_o, 0);
    chk("owner_rdata", (own == 1) ? l1v_rdata_o : l1b_rdata_o, rd);
    chk("other_rdata", (own == 1) ? l1b_rdata_o : l1v_rdata_o, last_rd[1-own]);
    chk("done_valid", iomem_valid_o, 0);
    last_rd[own] = rd;
    m_son        = own;
    tick;
    chk("pulse_1cyc", {l1b_ready_o, l1v_ready_o}, 0);
  endtask

  // One full transaction starting in BOSTA
  task automatic run_txn(input bit bv, input bit vv, input logic [16:0] ab, input logic [16:0] av,
                         input logic [31:0] wd, input logic [3:0] ws, input int wt,
                         input logic [31:0] rd, input int own);
    l1b_valid_i = bv;
    l1b_adr_i   = ab;
    l1v_valid_i = vv;
    l1v_adr_i   = av;
    l1v_wdata_i = wd;
    l1v_wstrb_i = ws;
    tick;
    check_grant(own, (own == 1) ? av : ab, wd, ws);
    for (int k = 0; k < wt; k++) begin
      tick;
      chk("wait_valid", iomem_valid_o, 1);
      chk("wait_ready", {l1b_ready_o, l1v_ready_o}, 0);
    end
    complete(own, rd, 1'b1, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Owners derived by hand from round-robin starting with last-served = l1v
    tbl[0] = '{1'b0, 1'b1, 17'h00000, 17'h00040, 32'h0, 4'h0, 2, 32'hCAFEF00D, 1};
    tbl[1] = '{1'b1, 1'b1, 17'h00100, 17'h00200, 32'h11110000, 4'h3, 0, 32'hA0000001, 0};
    tbl[2] = '{1'b1, 1'b1, 17'h00104, 17'h00204, 32'h22220000, 4'hC, 1, 32'hA0000002, 1};
    tbl[3] = '{1'b1, 1'b0, 17'h1FFFF, 17'h00000, 32'h0, 4'h0, 0, 32'hFFFFFFFF, 0};
    tbl[4] = '{1'b1, 1'b1, 17'h00001, 17'h1FFFF, 32'hFFFFFFFF, 4'hF, 3, 32'h00000000, 1};
    tbl[5] = '{1'b0, 1'b1, 17'h00002, 17'h00003, 32'h33330000, 4'h1, 0, 32'h5A5A5A5A, 1};
    tbl[6] = '{1'b1, 1'b1, 17'h00005, 17'h00006, 32'h44440000, 4'h8, 1, 32'hA5A5A5A5, 0};

    do_reset;
    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i].bv, tbl[i].vv, tbl[i].ab, tbl[i].av, tbl[i].wd, tbl[i].ws,
              tbl[i].wt, tbl[i].rd, tbl[i].own);
    end

    // Random traffic against the round-robin model
    for (int i = 0; i < 60; i++) begin
      bit bv, vv;
      int own;
      bv = 1'($urandom_range(0, 1));
      vv = bv ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bv && vv) own = 1 - m_son;
      else          own = vv ? 1 : 0;
      run_txn(bv, vv, 17'($urandom), 17'($urandom), $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 3), $urandom, own);
    end

    // Simultaneous requests after reset: l1b first, then l1v straight after CEVAP/BOSTA
    do_reset;
    l1b_valid_i = 1'b1;
    l1b_adr_i   = 17'h00100;
    l1v_valid_i = 1'b1;
    l1v_adr_i   = 17'h00200;
    l1v_wdata_i = 32'h12345678;
    l1v_wstrb_i = 4'hF;
    tick;
    check_grant(0, 17'h00100, 32'h0, 4'h0);
    complete(0, 32'hB0B0B0B0, 1'b1, 1'b0);
    chk("tie_bosta_valid", iomem_valid_o, 0);
    tick;
    check_grant(1, 17'h00200, 32'h12345678, 4'hF);
    complete(1, 32'h0BADBEEF, 1'b1, 1'b1);

    // Write-back, l1b arrives while busy, l1v holds valid for refill at a new address
    l1v_valid_i = 1'b1;
    l1v_adr_i   = 17'h00A00;
    l1v_wdata_i = 32'hDEADBEEF;
    l1v_wstrb_i = 4'hF;
    tick;
    check_grant(1, 17'h00A00, 32'hDEADBEEF, 4'hF);
    l1b_valid_i = 1'b1;
    l1b_adr_i   = 17'h00333;
    tick;
    chk("wb_hold_adr", iomem_adr_o, 17'h00A00);
    complete(1, 32'h00000000, 1'b0, 1'b0);
    l1v_adr_i   = 17'h00B00;
    l1v_wstrb_i = 4'h0;
    tick;
    check_grant(0, 17'h00333, 32'h0, 4'h0);
    complete(0, 32'h13572468, 1'b1, 1'b0);
    tick;
    check_grant(1, 17'h00B00, 32'hDEADBEEF, 4'h0);
    complete(1, 32'h2468ACE0, 1'b1, 1'b1);

    // Valid held through CEVAP only: exactly one transaction
    l1v_valid_i = 1'b1;
    l1v_adr_i   = 17'h00077;
    l1v_wstrb_i = 4'h0;
    tick;
    check_grant(1, 17'h00077, 32'hDEADBEEF, 4'h0);
    complete(1, 32'h77777777, 1'b0, 1'b0);
    l1v_valid_i = 1'b0;
    tick;
    chk("hold_no_regrant", iomem_valid_o, 0);
    tick;
    chk("hold_still_idle", iomem_valid_o, 0);

    // Reset in the middle of L1V_HIZMET, then a late memory answer
    l1v_valid_i = 1'b1;
    l1v_adr_i   = 17'h00123;
    tick;
    check_grant(1, 17'h00123, 32'hDEADBEEF, 4'h0);
    rst_ni      = 1'b0;
    l1v_valid_i = 1'b0;
    tick;
    rst_ni        = 1'b1;
    iomem_ready_i = 1'b1;
    iomem_rdata_i = 32'hFEEDFACE;
    chk("midrst_valid", iomem_valid_o, 0);
    tick;
    iomem_ready_i = 1'b0;
    chk("midrst_valid2", iomem_valid_o, 0);
    chk("midrst_ready", {l1b_ready_o, l1v_ready_o}, 0);
    chk("midrst_rdata_v", l1v_rdata_o, 0);
    tick;
    chk("midrst_ready2", {l1b_ready_o, l1v_ready_o}, 0);
    m_son      = 1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    run_txn(1'b1, 1'b1, 17'h00011, 17'h00022, 32'h0, 4'h0, 0, 32'h99990000, 0);

`ifdef ANABELLEK_ZAMAN_ASIMI_EN
    // Memory never answers: pulse with zero data after the 8th service cycle
    l1b_valid_i = 1'b1;
    l1b_adr_i   = 17'h00444;
    tick;
    check_grant(0, 17'h00444, 32'h0, 4'h0);
    for (int k = 1; k < 8; k++) begin
      tick;
      chk("to_wait_ready", {l1b_ready_o, l1v_ready_o}, 0);
      chk("to_wait_valid", iomem_valid_o, 1);
      chk("to_wait_hata", hata_o, 0);
    end
    tick;
    l1b_valid_i = 1'b0;
    chk("to_ready", l1b_ready_o, 1);
    chk("to_rdata", l1b_rdata_o, 32'h0);
    chk("to_valid", iomem_valid_o, 0);
    chk("to_hata", hata_o, 1);
    repeat (4) tick;
    chk("to_hata_sticky", hata_o, 1);
    chk("to_one_pulse", l1b_ready_o, 0);
    do_reset;
`else
    // Without the timeout the request stays up indefinitely
    l1b_valid_i = 1'b1;
    l1b_adr_i   = 17'h00444;
    tick;
    check_grant(0, 17'h00444, 32'h0, 4'h0);
    repeat (20) tick;
    chk("nto_valid", iomem_valid_o, 1);
    chk("nto_ready", {l1b_ready_o, l1v_ready_o}, 0);
    chk("nto_hata", hata_o, 0);
    complete(0, 32'h44440444, 1'b1, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
